// File: rtl/vector_mem_pkg.sv
// Shared widths and types for the vector memory arbiter and its helpers.
package vector_mem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 256;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

    typedef struct packed {
        logic              rden;
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   byteena;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// DEPTH-stage {valid, port} shift register that tracks reads in flight to the RAM.
module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_port,
    output logic o_valid,
    output logic o_port
);

    logic [DEPTH:0] w_valid;
    logic [DEPTH:0] w_port;

    assign w_valid[0] = i_valid;
    assign w_port[0]  = i_port;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic r_valid;
            logic r_port;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_valid <= 1'b0;
                    r_port  <= 1'b0;
                end else begin
                    r_valid <= w_valid[gi];
                    r_port  <= w_port[gi];
                end
            end

            assign w_valid[gi+1] = r_valid;
            assign w_port[gi+1]  = r_port;
        end
    endgenerate

    assign o_valid = w_valid[DEPTH];
    assign o_port  = w_port[DEPTH];

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter sharing one ip_ram port between the vector LSU (port 0) and
// the loader/DMA (port 1), with locked multi-beat ownership and tagged read returns.
module vector_mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 256,
    parameter int BE_W     = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              rden0,
    input  logic              rden1,
    input  logic              wren0,
    input  logic              wren1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BE_W-1:0]   byteena0,
    input  logic [BE_W-1:0]   byteena1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteena,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q
);
    import vector_mem_pkg::*;

    localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t        r_state, w_state_next;
    logic              r_last_winner, w_last_winner_next;
    logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_next, w_cnt_after;
    logic              w_gnt0, w_gnt1, w_any_gnt, w_lock, w_other_req;
    mem_req_t          w_req0, w_req1, w_sel;
    logic              w_tag_valid, w_tag_port, w_rvalid0, w_rvalid1;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;

    always_comb begin
        w_gnt0             = 1'b0;
        w_gnt1             = 1'b0;
        w_state_next       = r_state;
        w_last_winner_next = r_last_winner;
        w_beat_cnt_next    = r_beat_cnt;

        case (r_state)
            IDLE: begin
                w_gnt0 = req0 && (!req1 || r_last_winner);
                w_gnt1 = req1 && !w_gnt0;
            end
            OWN0:    w_gnt0 = req0;
            OWN1:    w_gnt1 = req1;
            default: ;
        endcase

        // Grants are suppressed while reset is held so no beat can issue mid-reset.
        if (!reset) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        w_lock      = w_gnt1 ? lock1 : lock0;
        w_other_req = w_gnt1 ? req0 : req1;

        if (r_state == IDLE)
            w_cnt_after = CNT_ONE;
        else if (r_beat_cnt >= CNT_MAX)
            w_cnt_after = CNT_MAX;
        else
            w_cnt_after = r_beat_cnt + CNT_ONE;

        // Forced release happens on the beat that fills the lock budget.
        if (w_gnt0 || w_gnt1) begin
            w_last_winner_next = w_gnt1;
            w_beat_cnt_next    = w_cnt_after;
            if (w_lock && !(w_other_req && (w_cnt_after == CNT_MAX)))
                w_state_next = w_gnt1 ? OWN1 : OWN0;
            else
                w_state_next = IDLE;
        end else if (r_state != IDLE) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_last_winner <= 1'b1;
            r_beat_cnt    <= '0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_last_winner <= w_last_winner_next;
            r_beat_cnt    <= w_beat_cnt_next;
            if (w_rvalid0) r_rdata0 <= ram_q;
            if (w_rvalid1) r_rdata1 <= ram_q;
        end
    end

    assign w_req0    = '{rden: rden0, wren: wren0, addr: addr0, byteena: byteena0, wdata: wdata0};
    assign w_req1    = '{rden: rden1, wren: wren1, addr: addr1, byteena: byteena1, wdata: wdata1};
    assign w_sel     = w_gnt1 ? w_req1 : w_req0;
    assign w_any_gnt = w_gnt0 || w_gnt1;

    // A beat flagged both read and write is treated as a write.
    assign ram_rden    = w_any_gnt && w_sel.rden && !w_sel.wren;
    assign ram_wren    = w_any_gnt && w_sel.wren;
    assign ram_address = w_any_gnt ? w_sel.addr    : '0;
    assign ram_byteena = w_any_gnt ? w_sel.byteena : '0;
    assign ram_wdata   = w_any_gnt ? w_sel.wdata   : '0;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (ram_rden),
        .i_port  (w_gnt1),
        .o_valid (w_tag_valid),
        .o_port  (w_tag_port)
    );

    assign w_rvalid0 = reset && w_tag_valid && !w_tag_port;
    assign w_rvalid1 = reset && w_tag_valid && w_tag_port;

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = w_rvalid0;
    assign rvalid1 = w_rvalid1;
    assign rdata0  = w_rvalid0 ? ram_q : r_rdata0;
    assign rdata1  = w_rvalid1 ? ram_q : r_rdata1;

    assert property (@(posedge clk) disable iff (!reset) !(req0 && rden0 && wren0));
    assert property (@(posedge clk) disable iff (!reset) !(req1 && rden1 && wren1));

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Directed bench for vector_mem_arbiter: grant timing checked inline, read returns and
// RAM writes checked by a queue-based scoreboard monitor.
module tb_vector_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 256;
    localparam int BW = 32;

    localparam logic [BW-1:0] BE1 = 32'hFFFF_FFE0;
    localparam logic [BW-1:0] BE2 = 32'h0000_001F;
    localparam logic [DW-1:0] W1  = {8{32'h1122_3344}};
    localparam logic [DW-1:0] W2  = {8{32'h5566_7788}};

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, lock0, lock1, rden0, rden1, wren0, wren1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] byteena0, byteena1;
    logic [DW-1:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1, ram_rden, ram_wren;
    logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_q;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteena;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] exp_rd0[$];
    logic [DW-1:0] exp_rd1[$];
    wr_t           exp_wr[$];

    logic [DW-1:0] mem [0:63];
    logic [AW-1:0] r_q_addr = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    vector_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .lock0       (lock0),
        .lock1       (lock1),
        .rden0       (rden0),
        .rden1       (rden1),
        .wren0       (wren0),
        .wren1       (wren1),
        .addr0       (addr0),
        .addr1       (addr1),
        .byteena0    (byteena0),
        .byteena1    (byteena1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .ram_rden    (ram_rden),
        .ram_wren    (ram_wren),
        .ram_address (ram_address),
        .ram_byteena (ram_byteena),
        .ram_wdata   (ram_wdata),
        .ram_q       (ram_q)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        for (int i = 0; i < BW; i++) v[i*8 +: 8] = a[7:0] + 8'(i);
        return v;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] v;
        v = old;
        for (int i = 0; i < BW; i++) if (be[i]) v[i*8 +: 8] = wd[i*8 +: 8];
        return v;
    endfunction

    // ip_ram model: registered address, unregistered q, byte-enabled writes.
    assign ram_q = mem[r_q_addr[5:0]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(AW'(i));
            mem_ready <= 1'b1;
        end else begin
            if (ram_rden) r_q_addr <= ram_address;
            if (ram_wren) mem[ram_address[5:0]] <= merge(mem[ram_address[5:0]], ram_wdata, ram_byteena);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv0(input logic rq, input logic lk, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req0 = rq; lock0 = lk; rden0 = rd; wren0 = wr; addr0 = a; byteena0 = be; wdata0 = d;
    endtask

    task automatic drv1(input logic rq, input logic lk, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req1 = rq; lock1 = lk; rden1 = rd; wren1 = wr; addr1 = a; byteena1 = be; wdata1 = d;
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic lk);
        drv0(1'b1, lk, 1'b1, 1'b0, a, '0, '0);
        exp_rd0.push_back(pat(a));
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic lk);
        drv1(1'b1, lk, 1'b1, 1'b0, a, '0, '0);
        exp_rd1.push_back(pat(a));
    endtask

    task automatic idle0();
        drv0(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic idle1();
        drv1(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a return or RAM write.
    initial begin
        logic [DW-1:0] e;
        wr_t           w;
        forever begin
            @(negedge clk);
            if (rvalid0) begin
                if (exp_rd0.size() == 0) chk("rvalid0_unexpected", DW'(rvalid0), '0);
                else begin
                    e = exp_rd0.pop_front();
                    chk("rdata0", rdata0, e);
                    $display("[%0t] port0 read return data=%h", $time, rdata0[31:0]);
                end
            end
            if (rvalid1) begin
                if (exp_rd1.size() == 0) chk("rvalid1_unexpected", DW'(rvalid1), '0);
                else begin
                    e = exp_rd1.pop_front();
                    chk("rdata1", rdata1, e);
                    $display("[%0t] port1 read return data=%h", $time, rdata1[31:0]);
                end
            end
            if (ram_wren) begin
                if (exp_wr.size() == 0) chk("ram_wren_unexpected", DW'(ram_wren), '0);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", DW'(ram_address), DW'(w.a));
                    chk("wr_be", DW'(ram_byteena), DW'(w.be));
                    chk("wr_data", ram_wdata, w.d);
                    $display("[%0t] ram write addr=%h be=%h", $time, ram_address, ram_byteena);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle0();
        idle1();
        drv0(1'b1, 1'b0, 1'b1, 1'b0, 14'h010, '0, '0);
        repeat (3) @(posedge clk);
        #4;
        chk("rst_gnt0", DW'(gnt0), '0);
        chk("rst_gnt1", DW'(gnt1), '0);
        chk("rst_rvalid0", DW'(rvalid0), '0);
        chk("rst_rvalid1", DW'(rvalid1), '0);
        chk("rst_ram_rden", DW'(ram_rden), '0);
        chk("rst_ram_wren", DW'(ram_wren), '0);
        chk("rst_ram_address", DW'(ram_address), '0);
        chk("rst_rdata0", rdata0, '0);
        chk("rst_rdata1", rdata1, '0);

        // Simultaneous single reads: port 0 wins the first tie.
        nc(); reset = 1'b1; rd0(14'h010, 1'b0); rd1(14'h020, 1'b0); #3;
        chk("t1_c0_gnt0", DW'(gnt0), DW'(1));
        chk("t1_c0_gnt1", DW'(gnt1), '0);
        chk("t1_c0_ram_rden", DW'(ram_rden), DW'(1));
        chk("t1_c0_ram_address", DW'(ram_address), DW'(14'h010));
        nc(); idle0(); #3;
        chk("t1_c1_gnt1", DW'(gnt1), DW'(1));
        chk("t1_c1_rvalid0", DW'(rvalid0), DW'(1));
        chk("t1_c1_ram_address", DW'(ram_address), DW'(14'h020));
        nc(); idle1(); #3;
        chk("t1_c2_rvalid1", DW'(rvalid1), DW'(1));
        chk("t1_c2_rvalid0", DW'(rvalid0), '0);
        nc(); #3;
        chk("t1_rdata0_held", rdata0, pat(14'h010));
        chk("t1_rdata1_held", rdata1, pat(14'h020));

        // Locked unaligned 2-beat write from port 0 while port 1 keeps requesting.
        nc();
        drv0(1'b1, 1'b1, 1'b0, 1'b1, 14'h005, BE1, W1);
        exp_wr.push_back('{a: 14'h005, be: BE1, d: W1});
        rd1(14'h030, 1'b0); #3;
        chk("t2_b1_gnt0", DW'(gnt0), DW'(1));
        chk("t2_b1_gnt1", DW'(gnt1), '0);
        nc();
        drv0(1'b1, 1'b0, 1'b0, 1'b1, 14'h006, BE2, W2);
        exp_wr.push_back('{a: 14'h006, be: BE2, d: W2});
        #3;
        chk("t2_b2_gnt0", DW'(gnt0), DW'(1));
        chk("t2_b2_gnt1", DW'(gnt1), '0);
        nc(); idle0(); #3;
        chk("t2_after_gnt1", DW'(gnt1), DW'(1));
        nc(); idle1(); #3;
        chk("t2_rvalid1", DW'(rvalid1), DW'(1));

        // Read back the merged words on alternating ports, back to back.
        nc(); drv0(1'b1, 1'b0, 1'b1, 1'b0, 14'h005, '0, '0);
        exp_rd0.push_back(merge(pat(14'h005), W1, BE1)); #3;
        chk("rb_gnt0", DW'(gnt0), DW'(1));
        nc(); idle0(); drv1(1'b1, 1'b0, 1'b1, 1'b0, 14'h006, '0, '0);
        exp_rd1.push_back(merge(pat(14'h006), W2, BE2)); #3;
        chk("rb_gnt1", DW'(gnt1), DW'(1));
        chk("rb_rvalid0", DW'(rvalid0), DW'(1));
        nc(); idle1(); #3;
        chk("rb_rvalid1", DW'(rvalid1), DW'(1));

        // Port 0 holds the lock: exactly 4 beats, then port 1 is forced in.
        nc(); rd0(14'h008, 1'b1); rd1(14'h009, 1'b0); #3;
        chk("t3_beat1_gnt0", DW'(gnt0), DW'(1));
        chk("t3_beat1_gnt1", DW'(gnt1), '0);
        for (int k = 1; k < 4; k++) begin
            nc(); rd0(AW'(8 + k), 1'b1); #3;
            chk("t3_lock_gnt0", DW'(gnt0), DW'(1));
            chk("t3_lock_gnt1", DW'(gnt1), '0);
        end
        nc(); rd0(14'h00C, 1'b1); #3;
        chk("t3_forced_gnt0", DW'(gnt0), '0);
        chk("t3_forced_gnt1", DW'(gnt1), DW'(1));
        nc(); idle1(); #3;
        chk("t3_resume_gnt0", DW'(gnt0), DW'(1));
        chk("t3_resume_rvalid1", DW'(rvalid1), DW'(1));
        nc(); idle0(); #3;
        chk("t3_release_gnt0", DW'(gnt0), '0);
        chk("t3_release_rvalid0", DW'(rvalid0), DW'(1));

        // Port 1 locks then drops req1: idle release hands the port to port 0.
        nc(); rd1(14'h011, 1'b1); #3;
        chk("t4_gnt1", DW'(gnt1), DW'(1));
        nc(); idle1(); rd0(14'h012, 1'b0); #3;
        chk("t4_own1_gnt0", DW'(gnt0), '0);
        chk("t4_own1_gnt1", DW'(gnt1), '0);
        nc(); rd1(14'h013, 1'b0); #3;
        chk("t4_release_gnt0", DW'(gnt0), DW'(1));
        chk("t4_release_gnt1", DW'(gnt1), '0);
        nc(); idle0(); #3;
        chk("t4_next_gnt1", DW'(gnt1), DW'(1));
        chk("t4_rvalid0", DW'(rvalid0), DW'(1));
        nc(); idle1(); #3;
        chk("t4_rvalid1", DW'(rvalid1), DW'(1));

        // Reset during OWN1 with a read in flight: that read must never return.
        nc(); drv1(1'b1, 1'b1, 1'b1, 1'b0, 14'h014, '0, '0); #3;
        chk("t5_gnt1", DW'(gnt1), DW'(1));
        nc(); reset = 1'b0; drv1(1'b1, 1'b1, 1'b1, 1'b0, 14'h015, '0, '0); #3;
        chk("t5_rst_gnt0", DW'(gnt0), '0);
        chk("t5_rst_gnt1", DW'(gnt1), '0);
        chk("t5_rst_rvalid0", DW'(rvalid0), '0);
        chk("t5_rst_rvalid1", DW'(rvalid1), '0);
        chk("t5_rst_ram_rden", DW'(ram_rden), '0);
        chk("t5_rst_ram_wren", DW'(ram_wren), '0);
        nc(); reset = 1'b1; rd0(14'h016, 1'b0); rd1(14'h017, 1'b0); #3;
        chk("t5_idle_gnt0", DW'(gnt0), DW'(1));
        chk("t5_idle_gnt1", DW'(gnt1), '0);
        chk("t5_no_stale_rvalid1", DW'(rvalid1), '0);
        nc(); idle0(); #3;
        chk("t5_next_gnt1", DW'(gnt1), DW'(1));
        chk("t5_rvalid0", DW'(rvalid0), DW'(1));
        nc(); idle1(); #3;
        chk("t5_rvalid1", DW'(rvalid1), DW'(1));

        repeat (3) nc();
        chk("rd0_queue_drained", DW'(exp_rd0.size()), '0);
        chk("rd1_queue_drained", DW'(exp_rd1.size()), '0);
        chk("wr_queue_drained", DW'(exp_wr.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_mem_arbiter.md
Name: vector_mem_arbiter

Overview:
- Shares the single 256-bit ip_ram port between two requesters:
  - port 0: the processor's vector load/store unit.
  - port 1: the external memory loader/host DMA, used for image/program preload and result readback.
- Performs round-robin arbitration.
- Supports locked multi-beat ownership, so a 2-beat unaligned vector access is never split.
- Tags read returns to their issuing requester.
- Sits between the datapath memory stage and the ip_ram instance.

Parameters:
- ADDR_W, 14, ip_ram word address width (256-bit words).
- DATA_W, 256, data width.
- BE_W, 32, byte-enable width (DATA_W/8).
- RD_LAT, 1, ip_ram read latency in cycles (registered address, unregistered q).
- MAX_LOCK, 4, maximum consecutive granted beats for one owner while the other port is requesting.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req0, req1  in  1  beat request from port 0 / port 1.
- lock0, lock1  in  1  hold ownership after this beat.
- rden0, rden1 / wren0, wren1  in  1  read / write beat (mutually exclusive per port).
- addr0, addr1  in  ADDR_W  word address.
- byteena0, byteena1  in  BE_W  write byte enables.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  beat accepted this cycle (combinational).
- rdata0, rdata1  out  DATA_W  read return data.
- rvalid0, rvalid1  out  1  rdataN valid this cycle.
- ram_rden, ram_wren  out  1  to ip_ram.
- ram_address  out  ADDR_W  to ip_ram.
- ram_byteena  out  BE_W  to ip_ram.
- ram_wdata  out  DATA_W  to ip_ram.
- ram_q  in  DATA_W  ip_ram read data.

Behaviour:
- Reset (reset==0 at posedge) sets:
  - state=IDLE, last_winner=1 (port 0 wins the first tie), beat_cnt=0, rd_tag pipeline cleared.
  - Outputs gnt*, rvalid*, ram_rden and ram_wren all 0; rdata* 0.
- Reset asserted mid-lock aborts ownership; no rvalid is produced for beats issued before reset.
- Beat rule: a beat on port N completes in the cycle where reqN && gntN.
  - The requester holds addr/data/rden/wren stable while reqN && !gntN.
- States are IDLE, OWN0 and OWN1.
- IDLE:
  - Only one port requests: grant it.
  - Both request: grant !last_winner.
  - On the granted beat, last_winner<=N and beat_cnt<=1.
  - If lockN=1 on that beat, next state is OWNN.
- OWNN:
  - Only port N can be granted, and it is granted whenever reqN=1.
  - The other port's gnt is 0.
  - Each granted beat increments beat_cnt, saturating at MAX_LOCK.
- Leaving OWNN for IDLE happens when any of these holds:
  - a granted beat has lockN=0;
  - reqN=0 for a cycle (idle release);
  - beat_cnt==MAX_LOCK and the other port's req=1 (forced release, takes effect after the current beat).
- A forced release sets last_winner=N, so the other port wins the next IDLE arbitration.
- IDLE arbitration is combinational, with a 0-cycle grant latency.
- RAM outputs:
  - Mux of the granted port's signals.
  - ram_rden = gnt && rden; ram_wren = gnt && wren.
  - All zero when there is no grant.
- Read return:
  - Tag shift register of depth RD_LAT holds {valid, port}.
  - A read granted at cycle t asserts rvalidN at t+RD_LAT with rdataN=ram_q.
  - The other port's rdata is held at its last value.
- A port with rden=wren=1 is illegal: assertion fires and the write takes precedence.
- Back-to-back reads from alternating ports return in issue order with no bubbles.
- Simultaneous write from port 0 and read from port 1 is serialized by arbitration; no RAM-level conflict is possible.

Decomposition:
- Package vector_mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  - typedef struct mem_req_t {rden, wren, addr, byteena, wdata};
  - constants ADDR_W, DATA_W, BE_W.
- One sub-module: rd_tag_pipe, a parameterized RD_LAT-deep {valid, port} shift register with synchronous active-low reset.

Test Plan:
- After reset release, both ports request a single read in the same cycle (addr0=0x010, addr1=0x020):
  - gnt0 at cycle 0, gnt1 at cycle 1.
  - rvalid0 at cycle 1 with mem[0x010]; rvalid1 at cycle 2 with mem[0x020].
- Port 0 issues an unaligned 2-beat write (addr 0x005 then 0x006, byteena 0xFFFFFFE0 then 0x0000001F, lock0=1 on beat 1) while port 1 requests continuously:
  - gnt1 stays 0 until both beats are done.
  - Port 1 is granted the cycle after beat 2.
- Port 0 holds lock0=1 with continuous requests while port 1 requests:
  - Exactly MAX_LOCK=4 beats to port 0, then forced release.
  - Port 1 is granted next, and last_winner=0 afterwards.
- Port 1 locks, then drops req1 for one cycle while port 0 requests:
  - Idle release; port 0 is granted the next cycle.
- Reset pulled low during OWN1 with a read in flight:
  - Next cycle all gnt/rvalid/ram_rden/ram_wren are 0 and state=IDLE.
  - No stale rvalid1 appears after reset release.
